pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Parametrised PLL lock supervisor and reset sequencer. It sits between the on-board reference clock, a vendor PLL instance and the design's reset tree. It drives the PLL's reset, watches its asynchronous lock flag and holds NUM_RST downstream resets until lock has been stable. It then releases those resets in a staggered order, and recovers from lock loss or lock timeout with bounded retries.

## Interface
- NUM_RST, default 3: number of sequenced reset outputs (1..8).
- PLL_RST_CYCLES, default 16: width of the PLL reset pulse, in refclk cycles (≥1).
- LOCK_TIMEOUT, default 4096: number of cycles to wait for lock before a retry.
- STABLE_CYCLES, default 1024: number of consecutive synchronised-lock cycles required before release.
- STAGGER, default 8: gap, in cycles, between successive reset releases.
- MAX_RETRIES, default 4: number of consecutive timeouts before entering FAULT.
- refclk in 1: the single clock for all logic (the PLL reference, not its output).
- reset in 1: asynchronous, active-high reset of all state.
- extlock in 1: PLL lock flag, asynchronous to refclk.
- retry_req in 1: single-cycle pulse; leaves FAULT only.
- pll_reset out 1: active-high reset to the PLL.
- rst_out out NUM_RST: active-high resets for downstream logic; each destination domain re-synchronises its own bit.
- locked out 1: high while in RELEASE or RUN.
- fault out 1: high in FAULT.
- retry_cnt out 3: consecutive lock-timeout count.
- loss_cnt out 8: lock-loss events from RELEASE or RUN; saturates at 255.

## Operation
- extlock passes through a 2-flop synchroniser (lock_s). No other logic reads extlock directly.
- Reset values: state=PLL_RST, pll_reset=1, rst_out all 1, locked=0, fault=0, retry_cnt=0, loss_cnt=0, cycle counter=0.
- PLL_RST: pll_reset=1 for PLL_RST_CYCLES cycles, then go to WAIT_LOCK with the counter cleared.
- WAIT_LOCK: pll_reset=0.
  - lock_s=1: go to STABLE.
  - Counter reaches LOCK_TIMEOUT-1 without lock: retry_cnt+1. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to PLL_RST.
- STABLE:
  - lock_s=0: go to WAIT_LOCK with the counter restarted. This is not a retry.
  - After STABLE_CYCLES consecutive cycles of lock_s=1: go to RELEASE and clear retry_cnt.
- RELEASE: rst_out[i] deasserts at entry + i·STAGGER cycles. Go to RUN in the cycle in which rst_out[NUM_RST-1] deasserts.
- RUN: steady state. All rst_out=0, locked=1.
- Lock loss (lock_s=0 in RELEASE or RUN): in the next cycle, all rst_out=1, locked=0, loss_cnt+1 (saturating), state=PLL_RST.
- FAULT: pll_reset=1, rst_out all 1, fault=1. Only retry_req or reset exits.
  - retry_req goes to PLL_RST and clears retry_cnt and fault.
  - retry_req in any other state is ignored.
- Counter width is $clog2 of the largest of the cycle parameters. All comparisons are made against parameter-1, so there are no off-by-one pulses.
- rst_out bits only ever fall in RELEASE. Every other state forces them to 1.

## Timing
- Lock latency: extlock rises at cycle 0 → lock_s=1 at cycle 2 → STABLE at cycle 3 → RELEASE, locked=1 and rst_out[0]=0 at cycle 3+STABLE_CYCLES.
  - Stated with lock_s already high: rst_out[0] falls STABLE_CYCLES cycles after STABLE is entered.
- rst_out[i] falls at cycle 3+STABLE_CYCLES+i·STAGGER.
- Lock-loss latency: from the extlock fall to all rst_out high is 3 cycles (2 sync + 1 registered).
- Timeout: pll_reset re-asserts exactly LOCK_TIMEOUT cycles after WAIT_LOCK entry.
- Simultaneous events:
  - Lock loss in the last RELEASE cycle: the loss wins, and the block does not enter RUN.
  - lock_s rising in the timeout cycle: the lock wins, and the block goes to STABLE.
- All outputs are registered. There is no combinational path from any input to any output.
- reset asserted mid-operation forces reset values immediately (asynchronously). Release is synchronous through the reset-deassert flop chain.

## Structure
- The shared package (pll_sup_pkg) holds:
  - state encoding constants: PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT (3-bit);
  - the default parameter constants.
- Sub-module: sync_2ff, a parameter-free 2-flop synchroniser with async active-high reset to 0. It is reused elsewhere for CDC of level signals.
- FSM, counter and stagger logic live in one always block plus registered output logic, with no further hierarchy.

## Test plan
- Reset, with extlock high at cycle 0: pll_reset high for 16 cycles.
  - locked=1 and rst_out=3'b110 at 3+1024 cycles after WAIT_LOCK entry.
  - rst_out=3'b100 at +8 cycles, and 3'b000 at +16 cycles.
- extlock held low with LOCK_TIMEOUT=64 and MAX_RETRIES=4: pll_reset pulses 4 times, then fault=1 with retry_cnt=4.
  - A retry_req pulse clears fault and gives pll_reset=1 next cycle.
- extlock drops for one cycle 500 cycles into STABLE: the state returns to WAIT_LOCK, and release happens 1024 cycles after the next lock, not earlier.
- extlock drops in RUN: all rst_out=1 three cycles later, loss_cnt=1, and the full sequence repeats. After 300 losses, loss_cnt=255.
- extlock drops in the cycle where rst_out[2] would fall: rst_out returns to 3'b111, the state never reaches RUN, and loss_cnt increments.
- reset asserted mid-RELEASE: all outputs return to their reset values within the same cycle, and the sequence restarts from PLL_RST.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared state encoding, default parameters and width helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } pll_state_t;

    localparam int DEF_NUM_RST        = 3;
    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 4096;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_STAGGER        = 8;
    localparam int DEF_MAX_RETRIES    = 4;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cnt_width(input int m);
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for level signals, async active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies lock, releases downstream
// resets in a staggered order and recovers from lock loss or timeout.
//
// state     | meaning
// PLL_RST   | PLL held in reset for PLL_RST_CYCLES
// WAIT_LOCK | waiting for synchronised lock, bounded by LOCK_TIMEOUT
// STABLE    | lock must stay high for STABLE_CYCLES
// RELEASE   | downstream resets deassert one per STAGGER cycles
// RUN       | all resets released, locked=1
// FAULT     | too many timeouts; waits for retry_req
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int NUM_RST        = DEF_NUM_RST,
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int STAGGER        = DEF_STAGGER,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic               refclk,
    input  logic               reset,
    input  logic               extlock,
    input  logic               retry_req,
    output logic               pll_reset,
    output logic [NUM_RST-1:0] rst_out,
    output logic               locked,
    output logic               fault,
    output logic [2:0]         retry_cnt,
    output logic [7:0]         loss_cnt
);

    localparam int LAST_REL = (NUM_RST - 1) * STAGGER;
    localparam int CW = cnt_width(max_of(max_of(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                         max_of(STABLE_CYCLES, LAST_REL + 1)));

    localparam logic [CW-1:0] T_PLL    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] T_LOCK   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] T_STABLE = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] T_LAST   = CW'(LAST_REL);
    localparam logic [2:0]    MAX_R    = 3'(MAX_RETRIES);

    // Bit i stays asserted until k cycles into RELEASE reaches i*STAGGER.
    function automatic logic [NUM_RST-1:0] rel_mask(input logic [CW-1:0] k);
        logic [NUM_RST-1:0] m;
        m = '1;
        for (int i = 0; i < NUM_RST; i++) begin
            m[i] = (int'(k) < i * STAGGER);
        end
        return m;
    endfunction

    pll_state_t    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          rst_done;
    logic          rst_int;
    logic          lock_s;

    assign cnt_inc = cnt + 1'b1;
    assign rst_int = ~rst_done;

    // Reset asserts asynchronously but releases two refclk edges later.
    sync_2ff u_rst_sync (
        .clk (refclk),
        .rst (reset),
        .d   (1'b1),
        .q   (rst_done)
    );

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (reset),
        .d   (extlock),
        .q   (lock_s)
    );

    always_ff @(posedge refclk or posedge rst_int) begin
        if (rst_int) begin
            state     <= PLL_RST;
            cnt       <= '0;
            pll_reset <= 1'b1;
            rst_out   <= '1;
            locked    <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= 3'd0;
            loss_cnt  <= 8'd0;
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == T_PLL) begin
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == T_LOCK) begin
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                        retry_cnt <= retry_cnt + 3'd1;
                        if (retry_cnt + 3'd1 == MAX_R) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= PLL_RST;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == T_STABLE) begin
                        state     <= (LAST_REL == 0) ? RUN : RELEASE;
                        cnt       <= '0;
                        retry_cnt <= 3'd0;
                        locked    <= 1'b1;
                        rst_out   <= rel_mask('0);
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RELEASE, RUN: begin
                    // Lock loss outranks the final release step.
                    if (!lock_s) begin
                        state     <= PLL_RST;
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                        rst_out   <= '1;
                        locked    <= 1'b0;
                        if (loss_cnt != 8'hFF) begin
                            loss_cnt <= loss_cnt + 8'd1;
                        end
                    end else if (state == RELEASE) begin
                        cnt     <= cnt_inc;
                        rst_out <= rel_mask(cnt_inc);
                        if (cnt_inc == T_LAST) begin
                            state <= RUN;
                        end
                    end
                end
                FAULT: begin
                    if (retry_req) begin
                        state     <= PLL_RST;
                        cnt       <= '0;
                        retry_cnt <= 3'd0;
                        fault     <= 1'b0;
                    end
                end
                default: begin
                    state     <= PLL_RST;
                    cnt       <= '0;
                    pll_reset <= 1'b1;
                    rst_out   <= '1;
                    locked    <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: lock, stagger, timeout/fault, glitch, loss and reset cases.
module tb_pll_lock_supervisor;

    logic       refclk = 1'b0;
    logic       reset;
    logic       extlock;
    logic       extlock_b;
    logic       retry_req;
    logic       pll_reset, locked, fault;
    logic [2:0] rst_out, retry_cnt;
    logic [7:0] loss_cnt;
    logic       pll_reset_b, locked_b, fault_b;
    logic [2:0] rst_out_b, retry_cnt_b;
    logic [7:0] loss_cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 refclk = ~refclk;

    pll_lock_supervisor #(
        .NUM_RST(3), .PLL_RST_CYCLES(16), .LOCK_TIMEOUT(64),
        .STABLE_CYCLES(1024), .STAGGER(8), .MAX_RETRIES(4)
    ) dut (
        .refclk(refclk), .reset(reset), .extlock(extlock), .retry_req(retry_req),
        .pll_reset(pll_reset), .rst_out(rst_out), .locked(locked), .fault(fault),
        .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
    );

    // Short stable window so hundreds of loss events fit in the run.
    pll_lock_supervisor #(
        .NUM_RST(3), .PLL_RST_CYCLES(16), .LOCK_TIMEOUT(64),
        .STABLE_CYCLES(4), .STAGGER(8), .MAX_RETRIES(4)
    ) dut_b (
        .refclk(refclk), .reset(reset), .extlock(extlock_b), .retry_req(retry_req),
        .pll_reset(pll_reset_b), .rst_out(rst_out_b), .locked(locked_b), .fault(fault_b),
        .retry_cnt(retry_cnt_b), .loss_cnt(loss_cnt_b)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; extlock = 1'b0; extlock_b = 1'b1; retry_req = 1'b0;
        step(3);
        n_cmp++;
        if ({pll_reset, rst_out, locked, fault, retry_cnt, loss_cnt} !== {1'b1, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0}) begin
            n_err++;
            $display("FAIL reset_values: got %b %b %b %b %0d %0d want 1 111 0 0 0 0",
                     pll_reset, rst_out, locked, fault, retry_cnt, loss_cnt);
        end
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (pll_reset) n++;
        end
        n_cmp++;
        if (n !== 16) begin
            n_err++; $display("FAIL reset_pll_pulse: high %0d of first 16 cycles want 16", n);
        end
        n = 0;
        while (pll_reset && n < 10) begin step(1); n++; end
        n_cmp++;
        if (pll_reset !== 1'b0) begin
            n_err++; $display("FAIL reset_pll_fall: pll_reset %b want 0", pll_reset);
        end
        extlock = 1'b1;
        step(1026);
        n_cmp++;
        if ({locked, rst_out} !== {1'b0, 3'b111}) begin
            n_err++; $display("FAIL lock_early: got %b %b want 0 111", locked, rst_out);
        end
        step(1);
        n_cmp++;
        if ({locked, rst_out} !== {1'b1, 3'b110}) begin
            n_err++; $display("FAIL lock_release: got %b %b want 1 110", locked, rst_out);
        end
        step(7);
        n_cmp++;
        if (rst_out !== 3'b110) begin
            n_err++; $display("FAIL stagger1_early: got %b want 110", rst_out);
        end
        step(1);
        n_cmp++;
        if (rst_out !== 3'b100) begin
            n_err++; $display("FAIL stagger1: got %b want 100", rst_out);
        end
        step(7);
        n_cmp++;
        if (rst_out !== 3'b100) begin
            n_err++; $display("FAIL stagger2_early: got %b want 100", rst_out);
        end
        step(1);
        n_cmp++;
        if ({locked, rst_out} !== {1'b1, 3'b000}) begin
            n_err++; $display("FAIL stagger2: got %b %b want 1 000", locked, rst_out);
        end
    endtask

    task automatic test_loss_run();
        step(5);
        extlock = 1'b0;
        step(2);
        n_cmp++;
        if ({locked, rst_out} !== {1'b1, 3'b000}) begin
            n_err++; $display("FAIL loss_hold: got %b %b want 1 000", locked, rst_out);
        end
        step(1);
        n_cmp++;
        if ({pll_reset, locked, rst_out, loss_cnt} !== {1'b1, 1'b0, 3'b111, 8'd1}) begin
            n_err++;
            $display("FAIL loss_reset: got %b %b %b %0d want 1 0 111 1", pll_reset, locked, rst_out, loss_cnt);
        end
    endtask

    task automatic test_timeout_fault();
        int hi, lo;
        logic exp_f;
        for (int k = 0; k < 4; k++) begin
            hi = 0;
            while (pll_reset && hi < 100) begin step(1); hi++; end
            n_cmp++;
            if (hi !== 16) begin
                n_err++; $display("FAIL timeout_pll_pulse[%0d]: high %0d want 16", k, hi);
            end
            lo = 0;
            while (!pll_reset && lo < 200) begin step(1); lo++; end
            n_cmp++;
            if (lo !== 64) begin
                n_err++; $display("FAIL timeout_wait[%0d]: low %0d want 64", k, lo);
            end
            exp_f = (k == 3);
            n_cmp++;
            if ({retry_cnt, fault} !== {3'(k + 1), exp_f}) begin
                n_err++;
                $display("FAIL timeout_count[%0d]: got %0d %b want %0d %b", k, retry_cnt, fault, k + 1, exp_f);
            end
        end
        step(20);
        n_cmp++;
        if ({fault, pll_reset, rst_out, retry_cnt} !== {1'b1, 1'b1, 3'b111, 3'd4}) begin
            n_err++;
            $display("FAIL fault_hold: got %b %b %b %0d want 1 1 111 4", fault, pll_reset, rst_out, retry_cnt);
        end
        retry_req = 1'b1;
        step(1);
        retry_req = 1'b0;
        n_cmp++;
        if ({fault, pll_reset, retry_cnt} !== {1'b0, 1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL retry_exit: got %b %b %0d want 0 1 0", fault, pll_reset, retry_cnt);
        end
    endtask

    task automatic test_retry_ignored();
        int n;
        n = 0;
        step(5); n += 5;
        retry_req = 1'b1;
        step(1); n++;
        retry_req = 1'b0;
        while (pll_reset && n < 100) begin step(1); n++; end
        n_cmp++;
        if (n !== 16) begin
            n_err++; $display("FAIL retry_ignored: pll_reset high %0d want 16", n);
        end
    endtask

    task automatic test_stable_glitch();
        extlock = 1'b1;
        step(3);
        step(500);
        extlock = 1'b0;
        step(1);
        extlock = 1'b1;
        step(523);
        n_cmp++;
        if ({locked, pll_reset, rst_out} !== {1'b0, 1'b0, 3'b111}) begin
            n_err++;
            $display("FAIL glitch_no_early_release: got %b %b %b want 0 0 111", locked, pll_reset, rst_out);
        end
        step(503);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_err++; $display("FAIL glitch_release_early: locked %b want 0", locked);
        end
        step(1);
        n_cmp++;
        if ({locked, rst_out} !== {1'b1, 3'b110}) begin
            n_err++; $display("FAIL glitch_release: got %b %b want 1 110", locked, rst_out);
        end
    endtask

    task automatic test_loss_last_release();
        int bad;
        step(13);
        extlock = 1'b0;
        step(2);
        n_cmp++;
        if ({locked, rst_out} !== {1'b1, 3'b100}) begin
            n_err++; $display("FAIL last_rel_before: got %b %b want 1 100", locked, rst_out);
        end
        step(1);
        n_cmp++;
        if ({locked, rst_out, loss_cnt} !== {1'b0, 3'b111, 8'd2}) begin
            n_err++;
            $display("FAIL last_rel_loss: got %b %b %0d want 0 111 2", locked, rst_out, loss_cnt);
        end
        extlock = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (locked || rst_out !== 3'b111) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++; $display("FAIL last_rel_no_run: %0d cycles released want 0", bad);
        end
    endtask

    task automatic test_reset_mid_release();
        int n;
        n = 0;
        while (!locked && n < 1200) begin step(1); n++; end
        n_cmp++;
        if (locked !== 1'b1) begin
            n_err++; $display("FAIL relock: locked %b want 1", locked);
        end
        step(4);
        #3 reset = 1'b1;
        #1;
        n_cmp++;
        if ({pll_reset, rst_out, locked, fault, retry_cnt, loss_cnt} !== {1'b1, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0}) begin
            n_err++;
            $display("FAIL async_reset: got %b %b %b %b %0d %0d want 1 111 0 0 0 0",
                     pll_reset, rst_out, locked, fault, retry_cnt, loss_cnt);
        end
        step(2);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (pll_reset && rst_out === 3'b111) n++;
        end
        n_cmp++;
        if (n !== 16) begin
            n_err++; $display("FAIL restart_pll_pulse: high %0d of 16 want 16", n);
        end
        n = 0;
        while (pll_reset && n < 10) begin step(1); n++; end
        n_cmp++;
        if ({pll_reset, loss_cnt} !== {1'b0, 8'd0}) begin
            n_err++; $display("FAIL restart_wait_lock: got %b %0d want 0 0", pll_reset, loss_cnt);
        end
    endtask

    task automatic test_loss_saturate();
        int  n;
        bit  to_err;
        to_err = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            n = 0;
            while (!locked_b && n < 300) begin step(1); n++; end
            if (!locked_b) to_err = 1'b1;
            extlock_b = 1'b0;
            n = 0;
            while (locked_b && n < 10) begin step(1); n++; end
            extlock_b = 1'b1;
            if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300) begin
                n_cmp++;
                if (loss_cnt_b !== 8'((i > 255) ? 255 : i)) begin
                    n_err++;
                    $display("FAIL loss_sat[%0d]: got %0d want %0d", i, loss_cnt_b, (i > 255) ? 255 : i);
                end
            end
        end
        n_cmp++;
        if (to_err !== 1'b0) begin
            n_err++; $display("FAIL sat_timeout: lock wait expired got %b want 0", to_err);
        end
        n_cmp++;
        if ({pll_reset_b, rst_out_b, fault_b, retry_cnt_b} !== {1'b1, 3'b111, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL sat_state: got %b %b %b %0d want 1 111 0 0", pll_reset_b, rst_out_b, fault_b, retry_cnt_b);
        end
    endtask

    initial begin
        test_reset();
        test_loss_run();
        test_timeout_fault();
        test_retry_ignored();
        test_stable_glitch();
        test_loss_last_release();
        test_reset_mid_release();
        test_loss_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
